deserializer_8bit: RTL and testbench

- Serial-in/parallel-out front end. Collects framed, strobed serial bits into a WIDTH-bit word and holds it in a one-entry output buffer with a valid/ready handshake.
- Its out_data/out_valid feed the d/en inputs of the downstream 8-bit enable register, with out_ready tied high when the register always accepts.
- Reports frame aborts and buffer overruns.

---
 rtl/deserializer_8bit.sv | 145 ++++++++++++++
 tb/tb_deserializer_8bit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/deserializer_8bit.sv
// Serial-in/parallel-out front end: collects framed, strobed serial bits into
// a WIDTH-bit word and holds it in a one-entry valid/ready output buffer.
// Flags dropped words (sticky overrun) and frames that end mid-word (frame_err).
module deserializer_8bit #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             frame,
   input  logic             sdi,
   input  logic             out_ready,
   input  logic             clr_overrun,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             overrun,
   output logic             frame_err,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] shift_r, shift_s;
   logic [WIDTH-1:0] shifted_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [WIDTH-1:0] data_r, data_s;
   logic             valid_r, valid_s;
   logic             overrun_r, overrun_s;
   logic             ferr_r, ferr_s;
   logic             busy_r;
   logic             word_done_s;
   logic             load_s;
   logic             ovr_set_s;

   // Shift register contents after taking in the current sdi bit.
   always_comb begin
      shifted_s = shift_r;
      if (MSB_FIRST) begin
         shifted_s = {shift_r[WIDTH-2:0], sdi};
      end else begin
         shifted_s = {sdi, shift_r[WIDTH-1:1]};
      end
   end

   // Framing FSM: next state, bit sampling, word completion and abort detection.
   always_comb begin
      state_s     = state_r;
      shift_s     = shift_r;
      cnt_s       = cnt_r;
      word_done_s = 1'b0;
      ferr_s      = 1'b0;
      case (state_r)
         IDLE, SHIFT: begin
            if (frame) begin
               // The entry cycle from IDLE already samples a strobed bit.
               state_s = SHIFT;
               if (bit_en) begin
                  shift_s = shifted_s;
                  if (cnt_r == LAST_BIT) begin
                     cnt_s       = {CW{1'b0}};
                     word_done_s = 1'b1;
                  end else begin
                     cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  cnt_s = cnt_r;
               end
            end else begin
               // Frame ended: drop any partial word; flag it only if bits were pending.
               state_s = IDLE;
               ferr_s  = (state_r == SHIFT) && (cnt_r != {CW{1'b0}});
               shift_s = {WIDTH{1'b0}};
               cnt_s   = {CW{1'b0}};
            end
         end
         default: begin
            state_s = IDLE;
            shift_s = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
         end
      endcase
   end

   // Output buffer: load on completion when free or being drained, else flag overrun.
   always_comb begin
      load_s    = word_done_s && (!valid_r || out_ready);
      ovr_set_s = word_done_s && valid_r && !out_ready;
      data_s    = data_r;
      valid_s   = valid_r;
      if (load_s) begin
         data_s  = shifted_s;
         valid_s = 1'b1;
      end else if (valid_r && out_ready) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end
      // A new overrun outranks a simultaneous clear.
      if (ovr_set_s) begin
         overrun_s = 1'b1;
      end else if (clr_overrun) begin
         overrun_s = 1'b0;
      end else begin
         overrun_s = overrun_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         shift_r   <= {WIDTH{1'b0}};
         cnt_r     <= {CW{1'b0}};
         data_r    <= {WIDTH{1'b0}};
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
         ferr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         cnt_r     <= cnt_s;
         data_r    <= data_s;
         valid_r   <= valid_s;
         overrun_r <= overrun_s;
         ferr_r    <= ferr_s;
         busy_r    <= (state_s == SHIFT);
      end
   end

   assign out_data  = data_r;
   assign out_valid = valid_r;
   assign overrun   = overrun_r;
   assign frame_err = ferr_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_deserializer_8bit.sv
// Self-checking bench for deserializer_8bit: an MSB-first and an LSB-first
// instance share stimulus; a queue-based word model checks both every cycle.
module tb_deserializer_8bit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, bit_en, frame, sdi, out_ready, clr_overrun;
   logic [W-1:0] data_m, data_l;
   logic         valid_m, valid_l, ovr_m, ovr_l, ferr_m, ferr_l, busy_m, busy_l;

   int n_cmp = 0;
   int n_err = 0;

   // Model state
   int           q[$];
   logic [W-1:0] e_data_m, e_data_l;
   logic         e_valid, e_ovr, e_ferr, e_busy;

   always #5 clk = ~clk;

   deserializer_8bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .bit_en(bit_en), .frame(frame), .sdi(sdi),
      .out_ready(out_ready), .clr_overrun(clr_overrun),
      .out_data(data_m), .out_valid(valid_m), .overrun(ovr_m),
      .frame_err(ferr_m), .busy(busy_m)
   );

   deserializer_8bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .bit_en(bit_en), .frame(frame), .sdi(sdi),
      .out_ready(out_ready), .clr_overrun(clr_overrun),
      .out_data(data_l), .out_valid(valid_l), .overrun(ovr_l),
      .frame_err(ferr_l), .busy(busy_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      logic         done;
      logic [W-1:0] wm, wl;
      logic         accept, ovr_set;
      done = 1'b0;
      wm = '0;
      wl = '0;
      if (rst) begin
         q.delete();
         e_data_m = '0; e_data_l = '0;
         e_valid = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0; e_busy = 1'b0;
      end else begin
         e_ferr = 1'b0;
         if (frame) begin
            if (bit_en) begin
               q.push_back(int'(sdi));
               if (q.size() == W) begin
                  done = 1'b1;
                  for (int i = 0; i < W; i++) begin
                     wm = wm | (W'(q[i]) << (W - 1 - i));
                     wl = wl | (W'(q[i]) << i);
                  end
                  q.delete();
               end
            end
         end else begin
            if (q.size() != 0) e_ferr = 1'b1;
            q.delete();
         end
         accept  = e_valid && out_ready;
         ovr_set = done && e_valid && !out_ready;
         if (done && !ovr_set) begin
            e_data_m = wm;
            e_data_l = wl;
            e_valid  = 1'b1;
         end else if (accept) begin
            e_valid = 1'b0;
         end
         if (ovr_set) e_ovr = 1'b1;
         else if (clr_overrun) e_ovr = 1'b0;
         e_busy = frame;
      end
   endtask

   task automatic compare_all();
      chk("data_msb",  32'(data_m),  32'(e_data_m));
      chk("data_lsb",  32'(data_l),  32'(e_data_l));
      chk("valid",     {30'd0, valid_m, valid_l}, {30'd0, e_valid, e_valid});
      chk("overrun",   {30'd0, ovr_m, ovr_l},     {30'd0, e_ovr, e_ovr});
      chk("frame_err", {30'd0, ferr_m, ferr_l},   {30'd0, e_ferr, e_ferr});
      chk("busy",      {30'd0, busy_m, busy_l},   {30'd0, e_busy, e_busy});
   endtask

   // One clock: inputs are already driven; update model at the edge, compare 1 time unit later.
   task automatic step(input logic f, input logic be, input logic d,
                       input logic rdy, input logic clr, input logic r);
      frame = f; bit_en = be; sdi = d; out_ready = rdy; clr_overrun = clr; rst = r;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // Send WIDTH bits of w, MSB of w first on sdi, frame held high.
   task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic gaps);
      for (int i = 0; i < W; i++) begin
         if (gaps) step(1'b1, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
         step(1'b1, 1'b1, w[W-1-i], rdy, 1'b0, 1'b0);
      end
   endtask

   initial begin
      frame = 1'b0; bit_en = 1'b0; sdi = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0; rst = 1'b1;

      // Reset with random inputs
      for (int i = 0; i < 2; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      chk("rst_valid", 32'(valid_m), 32'd0);
      chk("rst_data", 32'(data_m), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_valid", 32'(valid_m), 32'd0);

      // MSB-first A5, held, then accepted
      send_word(8'hA5, 1'b0, 1'b0);
      chk("a5_msb_data", 32'(data_m), 32'h0000_00A5);
      chk("a5_valid", 32'(valid_m), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("a5_accepted", 32'(valid_m), 32'd0);

      // Same bits with bit_en gaps; A5 is a bit palindrome so the LSB instance also gives A5
      send_word(8'hA5, 1'b1, 1'b1);
      chk("a5_lsb_data", 32'(data_l), 32'h0000_00A5);
      chk("gap_ferr", 32'(ferr_l), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Back-to-back with simultaneous accept
      send_word(8'h3C, 1'b1, 1'b0);
      chk("b2b_first", 32'(data_m), 32'h0000_003C);
      send_word(8'hC3, 1'b1, 1'b0);
      chk("b2b_second", 32'(data_m), 32'h0000_00C3);
      chk("b2b_ovr", 32'(ovr_m), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Overrun
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      chk("ovr_data_msb", 32'(data_m), 32'h0000_0011);
      chk("ovr_data_lsb", 32'(data_l), 32'h0000_0088);
      chk("ovr_flag", 32'(ovr_m), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovr_clr", 32'(ovr_m), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Frame abort after 5 bits
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_ferr", 32'(ferr_m), 32'd1);
      chk("abort_buf", 32'(data_m), 32'h0000_0011);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_pulse", 32'(ferr_m), 32'd0);
      send_word(8'hF0, 1'b1, 1'b0);
      chk("f0_msb", 32'(data_m), 32'h0000_00F0);
      chk("f0_lsb", 32'(data_l), 32'h0000_000F);

      // Reset after 3 bits: no frame_err, count restarts
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("rst_ferr", 32'(ferr_m), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_ferr2", 32'(ferr_m), 32'd0);
      send_word(8'h5A, 1'b1, 1'b0);
      chk("post_rst_word", 32'(data_m), 32'h0000_005A);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 299) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
